// File: rtl/ex_mem_branch_if.sv
// ---------------------------------------------------------------------------
// ex_mem_branch_if
//   Bundles the EX-side inputs and the MEM-side registered outputs of the
//   EX/MEM pipeline register.
//
//   Modports:
//     master : the EX stage / environment; drives the *_in fields and
//              observes the registered outputs.
//     slave  : the EX/MEM register itself; consumes *_in and drives the
//              registered outputs.
//
//   Parameters:
//     B  : datapath width (PC, offsets, ALU result, store data)
//     RW : register-file address width
// ---------------------------------------------------------------------------
interface ex_mem_branch_if #(
  parameter int B  = 32,
  parameter int RW = 5
);

  // EX-stage side
  logic          valid_in;
  logic [B-1:0]  pc_plus4_in;
  logic [B-1:0]  offset_in;
  logic [B-1:0]  alu_result_in;
  logic          alu_zero_in;
  logic [B-1:0]  rt_data_in;
  logic [RW-1:0] write_reg_in;
  logic          branch_in;
  logic          branch_ne_in;
  logic          reg_write_in;
  logic          mem_to_reg_in;
  logic          mem_read_in;
  logic          mem_write_in;

  // MEM-stage side (registered)
  logic          valid_out;
  logic [B-1:0]  branch_target;
  logic          pc_src;
  logic [B-1:0]  alu_result_out;
  logic [B-1:0]  rt_data_out;
  logic [RW-1:0] write_reg_out;
  logic          reg_write_out;
  logic          mem_to_reg_out;
  logic          mem_read_out;
  logic          mem_write_out;

  modport master (
    output valid_in, pc_plus4_in, offset_in, alu_result_in, alu_zero_in,
           rt_data_in, write_reg_in, branch_in, branch_ne_in,
           reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in,
    input  valid_out, branch_target, pc_src, alu_result_out, rt_data_out,
           write_reg_out, reg_write_out, mem_to_reg_out, mem_read_out,
           mem_write_out
  );

  modport slave (
    input  valid_in, pc_plus4_in, offset_in, alu_result_in, alu_zero_in,
           rt_data_in, write_reg_in, branch_in, branch_ne_in,
           reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in,
    output valid_out, branch_target, pc_src, alu_result_out, rt_data_out,
           write_reg_out, reg_write_out, mem_to_reg_out, mem_read_out,
           mem_write_out
  );

endinterface : ex_mem_branch_if

// File: rtl/ex_mem_branch_latch.sv
// ---------------------------------------------------------------------------
// ex_mem_branch_latch
//   EX/MEM pipeline register of the 5-stage MIPS core. Computes the branch
//   target (PC+4 plus the already word-aligned offset), resolves beq/bne from
//   the ALU zero flag, and registers target, taken decision, ALU result,
//   store data, destination register and the MEM/WB controls.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset (clears every output)
//     stall  : 1 = hold every output register
//     flush  : 1 = load a bubble (all outputs 0); wins over stall
//     bus    : ex_mem_branch_if.slave -- EX inputs and registered outputs
//
//   Every output is a flop; there is no combinational input->output path.
//   Per-edge priority: reset > flush > stall > load.
//   The hazard unit is responsible for flushing IF/ID/EX when pc_src rises;
//   this register never flushes itself.
// ---------------------------------------------------------------------------
module ex_mem_branch_latch #(
  parameter int B  = 32,
  parameter int RW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  ex_mem_branch_if.slave bus
);

  // -------------------------------------------------------------------------
  // EX-side combinational terms
  // -------------------------------------------------------------------------
  logic [B-1:0] target_sum;
  logic         taken;

  // Truncating add: carry out of bit B-1 is dropped, so targets wrap modulo
  // 2**B and a two's-complement offset naturally branches backwards.
  assign target_sum = bus.pc_plus4_in + bus.offset_in;

  // With both beq and bne set, exactly one of the terms fires, so the
  // branch is taken whenever the instruction is valid.
  assign taken = bus.valid_in &
                 ((bus.branch_in    &  bus.alu_zero_in) |
                  (bus.branch_ne_in & ~bus.alu_zero_in));

  // -------------------------------------------------------------------------
  // Pipeline register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // Reset and flush both leave a clean bubble; flush also overrides a
      // simultaneous stall so a squashed instruction cannot survive a hold.
      bus.valid_out      <= 1'b0;
      bus.branch_target  <= '0;
      bus.pc_src         <= 1'b0;
      bus.alu_result_out <= '0;
      bus.rt_data_out    <= '0;
      bus.write_reg_out  <= '0;
      bus.reg_write_out  <= 1'b0;
      bus.mem_to_reg_out <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.mem_write_out  <= 1'b0;
    end else if (!stall) begin
      bus.valid_out      <= bus.valid_in;
      bus.branch_target  <= target_sum;
      bus.pc_src         <= taken;
      bus.alu_result_out <= bus.alu_result_in;
      bus.rt_data_out    <= bus.rt_data_in;
      bus.write_reg_out  <= bus.write_reg_in;
      // Controls are qualified by valid so a bubble can never write the
      // register file or memory downstream.
      bus.reg_write_out  <= bus.reg_write_in  & bus.valid_in;
      bus.mem_to_reg_out <= bus.mem_to_reg_in & bus.valid_in;
      bus.mem_read_out   <= bus.mem_read_in   & bus.valid_in;
      bus.mem_write_out  <= bus.mem_write_in  & bus.valid_in;
    end
    // stall without flush: no assignment, every flop holds.
  end

endmodule : ex_mem_branch_latch

// File: tb/tb_ex_mem_branch_latch.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_branch_latch
//   Directed self-checking bench for ex_mem_branch_latch. Inputs are driven
//   1 time unit after each rising edge; outputs are sampled 1 time unit after
//   the edge that registers them. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_ex_mem_branch_latch;

  localparam int B  = 32;
  localparam int RW = 5;

  logic clk;
  logic reset;
  logic stall;
  logic flush;

  int tests_run;
  int tests_failed;

  ex_mem_branch_if #(.B(B), .RW(RW)) bus ();

  ex_mem_branch_latch #(.B(B), .RW(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and, on mismatch, counts the failure.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // ctl = {reg_write, mem_to_reg, mem_read, mem_write}
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] off,
                       input logic [31:0] alu, input logic zero, input logic [31:0] rt,
                       input logic [4:0] wr, input logic br, input logic bne,
                       input logic [3:0] ctl);
    bus.valid_in      = v;
    bus.pc_plus4_in   = pc;
    bus.offset_in     = off;
    bus.alu_result_in = alu;
    bus.alu_zero_in   = zero;
    bus.rt_data_in    = rt;
    bus.write_reg_in  = wr;
    bus.branch_in     = br;
    bus.branch_ne_in  = bne;
    bus.reg_write_in  = ctl[3];
    bus.mem_to_reg_in = ctl[2];
    bus.mem_read_in   = ctl[1];
    bus.mem_write_in  = ctl[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string step, input logic v, input logic [31:0] tgt,
                            input logic ps, input logic [31:0] alu, input logic [31:0] rt,
                            input logic [4:0] wr, input logic [3:0] ctl);
    check($sformatf("%s valid_out", step),      {31'd0, bus.valid_out},      {31'd0, v});
    check($sformatf("%s branch_target", step),  bus.branch_target,           tgt);
    check($sformatf("%s pc_src", step),         {31'd0, bus.pc_src},         {31'd0, ps});
    check($sformatf("%s alu_result_out", step), bus.alu_result_out,          alu);
    check($sformatf("%s rt_data_out", step),    bus.rt_data_out,             rt);
    check($sformatf("%s write_reg_out", step),  {27'd0, bus.write_reg_out},  {27'd0, wr});
    check($sformatf("%s controls", step),
          {28'd0, bus.reg_write_out, bus.mem_to_reg_out, bus.mem_read_out, bus.mem_write_out},
          {28'd0, ctl});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stall = 1'b0;
    flush = 1'b0;

    // 1: reset held two cycles with non-zero inputs, then first load.
    reset = 1'b1;
    drive(1'b1, 32'h100, 32'h20, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555, 5'd7, 1'b1, 1'b0, 4'b1111);
    tick();
    expect_out("reset1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);
    tick();
    expect_out("reset2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);
    reset = 1'b0;
    tick();
    expect_out("beq_taken", 1'b1, 32'h120, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 5'd7, 4'b1111);

    // 2: beq not taken (zero=0); target still computed.
    drive(1'b1, 32'h100, 32'h20, 32'h1234, 1'b0, 32'h10, 5'd3, 1'b1, 1'b0, 4'b1000);
    tick();
    expect_out("beq_not_taken", 1'b1, 32'h120, 1'b0, 32'h1234, 32'h10, 5'd3, 4'b1000);

    // 3: bne backward branch, then wrap-around target with bne not taken.
    drive(1'b1, 32'h40, 32'hFFFF_FFF0, 32'h40, 1'b0, 32'h99, 5'd8, 1'b0, 1'b1, 4'b1100);
    tick();
    expect_out("bne_backward", 1'b1, 32'h30, 1'b1, 32'h40, 32'h99, 5'd8, 4'b1100);
    drive(1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b1, 4'b0000);
    tick();
    expect_out("wrap", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);

    // beq and bne both set: taken whenever valid.
    drive(1'b1, 32'h200, 32'h4, 32'h77, 1'b0, 32'h66, 5'd31, 1'b1, 1'b1, 4'b0010);
    tick();
    expect_out("beq_and_bne", 1'b1, 32'h204, 1'b1, 32'h77, 32'h66, 5'd31, 4'b0010);

    // 4: stall three cycles with changing inputs; pc_src=1 must be held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 32'h1000 + 32'(i), 32'h10, 32'hF0 + 32'(i), i[0], 32'h300 + 32'(i),
            5'(i + 1), 1'b1, 1'b0, 4'b0101);
      tick();
      expect_out($sformatf("stall%0d", i), 1'b1, 32'h204, 1'b1, 32'h77, 32'h66, 5'd31, 4'b0010);
    end

    // flush together with stall: bubble wins.
    flush = 1'b1;
    tick();
    expect_out("flush_stall", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);
    flush = 1'b0;
    stall = 1'b0;

    // 5: invalid instruction must not branch or write; data still copied.
    drive(1'b0, 32'h300, 32'h10, 32'hBEEF, 1'b1, 32'hCAFE, 5'd9, 1'b1, 1'b0, 4'b1111);
    tick();
    expect_out("bubble_in", 1'b0, 32'h310, 1'b0, 32'hBEEF, 32'hCAFE, 5'd9, 4'b0000);

    // flush alone over a valid taken branch.
    flush = 1'b1;
    drive(1'b1, 32'h300, 32'h10, 32'hBEEF, 1'b1, 32'hCAFE, 5'd9, 1'b1, 1'b0, 4'b1111);
    tick();
    expect_out("flush_only", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);
    flush = 1'b0;

    // 6: back-to-back taken branches, each with its own target.
    drive(1'b1, 32'h400, 32'h40, 32'h1, 1'b1, 32'h2, 5'd4, 1'b1, 1'b0, 4'b0001);
    tick();
    expect_out("b2b_first", 1'b1, 32'h440, 1'b1, 32'h1, 32'h2, 5'd4, 4'b0001);
    drive(1'b1, 32'h500, 32'hFFFF_FF00, 32'h3, 1'b0, 32'h5, 5'd6, 1'b0, 1'b1, 4'b0010);
    tick();
    expect_out("b2b_second", 1'b1, 32'h400, 1'b1, 32'h3, 32'h5, 5'd6, 4'b0010);
    drive(1'b1, 32'h10, 32'hFFFF_FFF0, 32'h8, 1'b1, 32'h9, 5'd10, 1'b1, 1'b0, 4'b1010);
    tick();
    expect_out("b2b_third", 1'b1, 32'h0, 1'b1, 32'h8, 32'h9, 5'd10, 4'b1010);

    // Reset mid-stream with a taken branch still on the inputs.
    reset = 1'b1;
    tick();
    expect_out("reset_mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0000);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ex_mem_branch_latch
